// File: rtl/umi_messages_pkg.sv
// UMI opcode codes, command-word field positions and the packed command layout.
package umi_messages_pkg;

  localparam int unsigned UMI_CMD_W = 32;

  localparam logic [4:0] UMI_INVALID    = 5'h00;
  localparam logic [4:0] UMI_REQ_READ   = 5'h01;
  localparam logic [4:0] UMI_RESP_READ  = 5'h02;
  localparam logic [4:0] UMI_REQ_WRITE  = 5'h03;
  localparam logic [4:0] UMI_RESP_WRITE = 5'h04;
  localparam logic [4:0] UMI_REQ_ATOMIC = 5'h09;
  localparam logic [4:0] UMI_RESP_LINK  = 5'h0E;
  localparam logic [4:0] UMI_REQ_LINK   = 5'h0F;

  localparam int unsigned UMI_OPCODE_MSB = 4;
  localparam int unsigned UMI_OPCODE_LSB = 0;
  localparam int unsigned UMI_SIZE_MSB   = 7;
  localparam int unsigned UMI_SIZE_LSB   = 5;
  localparam int unsigned UMI_LEN_MSB    = 15;
  localparam int unsigned UMI_LEN_LSB    = 8;
  localparam int unsigned UMI_QOS_MSB    = 19;
  localparam int unsigned UMI_QOS_LSB    = 16;
  localparam int unsigned UMI_PROT_MSB   = 21;
  localparam int unsigned UMI_PROT_LSB   = 20;
  localparam int unsigned UMI_EOM_BIT    = 22;
  localparam int unsigned UMI_EOF_BIT    = 23;
  localparam int unsigned UMI_USER_MSB   = 25;
  localparam int unsigned UMI_USER_LSB   = 24;
  localparam int unsigned UMI_EX_BIT     = 26;
  localparam int unsigned UMI_HOSTID_MSB = 31;
  localparam int unsigned UMI_HOSTID_LSB = 27;

  // Non-link command layout, MSB first.
  typedef struct packed {
    logic [UMI_HOSTID_MSB-UMI_HOSTID_LSB:0] hostid;
    logic                                   ex;
    logic [UMI_USER_MSB-UMI_USER_LSB:0]     user;
    logic                                   eof;
    logic                                   eom;
    logic [UMI_PROT_MSB-UMI_PROT_LSB:0]     prot;
    logic [UMI_QOS_MSB-UMI_QOS_LSB:0]       qos;
    logic [UMI_LEN_MSB-UMI_LEN_LSB:0]       len;
    logic [UMI_SIZE_MSB-UMI_SIZE_LSB:0]     size;
    logic [UMI_OPCODE_MSB-UMI_OPCODE_LSB:0] opcode;
  } umi_cmd_t;

  function automatic logic umi_is_link(input logic [4:0] op);
    return (op == UMI_REQ_LINK) || (op == UMI_RESP_LINK);
  endfunction

  // Responses are even, non-zero opcodes.
  function automatic logic umi_is_resp(input logic [4:0] op);
    return (op[0] == 1'b0) && (op != UMI_INVALID);
  endfunction

endpackage

// File: rtl/umi_cmd_pack.sv
// Packs decoded UMI command fields into a CW-bit command word.
// Define UMI_CMD_PACK_REG_EN to register packet_cmd (1-cycle latency, async clear).
module umi_cmd_pack
  import umi_messages_pkg::*;
#(
  parameter int unsigned CW = 32
) (
  input  logic          clk,
  input  logic          nreset,
  input  logic [4:0]    cmd_opcode,
  input  logic [2:0]    cmd_size,
  input  logic [7:0]    cmd_len,
  input  logic [7:0]    cmd_atype,
  input  logic [1:0]    cmd_prot,
  input  logic [3:0]    cmd_qos,
  input  logic          cmd_eom,
  input  logic          cmd_eof,
  input  logic [1:0]    cmd_user,
  input  logic [1:0]    cmd_err,
  input  logic          cmd_ex,
  input  logic [4:0]    cmd_hostid,
  input  logic [23:0]   cmd_user_extended,
  output logic [CW-1:0] packet_cmd
);

  generate
    if (CW < UMI_CMD_W) begin : g_cw_illegal
      $error("umi_cmd_pack: CW must be at least 32");
    end
  endgenerate

  umi_cmd_t              fields_c;
  logic [UMI_CMD_W-1:0]  word_c;

  // Field placement; link opcodes reuse [31:8] for the extended user payload.
  always_comb begin
    fields_c        = '0;
    fields_c.opcode = cmd_opcode;
    fields_c.size   = cmd_size;
    fields_c.len    = (cmd_opcode == UMI_REQ_ATOMIC) ? cmd_atype : cmd_len;
    fields_c.qos    = cmd_qos;
    fields_c.prot   = cmd_prot;
    fields_c.eom    = cmd_eom;
    fields_c.eof    = cmd_eof;
    fields_c.user   = umi_is_resp(cmd_opcode) ? cmd_err : cmd_user;
    fields_c.ex     = cmd_ex;
    fields_c.hostid = cmd_hostid;
    word_c          = fields_c;
    if (umi_is_link(cmd_opcode)) begin
      word_c = {cmd_user_extended, cmd_size, cmd_opcode};
    end
  end

`ifdef UMI_CMD_PACK_REG_EN
  logic [CW-1:0] packet_q;
  logic [CW-1:0] packet_d;

  assign packet_d = CW'(word_c);

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      packet_q <= '0;
    end else begin
      packet_q <= packet_d;
    end
  end

  assign packet_cmd = packet_q;
`else
  // Clock and reset are intentionally left unconnected in the combinational build.
  logic unused_clk_rst;
  assign unused_clk_rst = &{1'b0, clk, nreset};

  assign packet_cmd = CW'(word_c);
`endif

endmodule

// File: tb/tb_umi_cmd_pack.sv
// Directed-vector bench for umi_cmd_pack; covers the UMI_CMD_PACK_REG_EN build when defined.
module tb_umi_cmd_pack;

  localparam int unsigned CW = 32;

  logic          clk;
  logic          nreset;
  logic [4:0]    cmd_opcode;
  logic [2:0]    cmd_size;
  logic [7:0]    cmd_len;
  logic [7:0]    cmd_atype;
  logic [1:0]    cmd_prot;
  logic [3:0]    cmd_qos;
  logic          cmd_eom;
  logic          cmd_eof;
  logic [1:0]    cmd_user;
  logic [1:0]    cmd_err;
  logic          cmd_ex;
  logic [4:0]    cmd_hostid;
  logic [23:0]   cmd_user_extended;
  logic [CW-1:0] packet_cmd;

  int unsigned n_vec;
  int unsigned n_miss;

  umi_cmd_pack #(.CW(CW)) dut (
    .clk               (clk),
    .nreset            (nreset),
    .cmd_opcode        (cmd_opcode),
    .cmd_size          (cmd_size),
    .cmd_len           (cmd_len),
    .cmd_atype         (cmd_atype),
    .cmd_prot          (cmd_prot),
    .cmd_qos           (cmd_qos),
    .cmd_eom           (cmd_eom),
    .cmd_eof           (cmd_eof),
    .cmd_user          (cmd_user),
    .cmd_err           (cmd_err),
    .cmd_ex            (cmd_ex),
    .cmd_hostid        (cmd_hostid),
    .cmd_user_extended (cmd_user_extended),
    .packet_cmd        (packet_cmd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_vec(input string tag, input logic [CW-1:0] got, input logic [CW-1:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  task automatic clr_fields();
    cmd_opcode        = '0;
    cmd_size          = '0;
    cmd_len           = '0;
    cmd_atype         = '0;
    cmd_prot          = '0;
    cmd_qos           = '0;
    cmd_eom           = 1'b0;
    cmd_eof           = 1'b0;
    cmd_user          = '0;
    cmd_err           = '0;
    cmd_ex            = 1'b0;
    cmd_hostid        = '0;
    cmd_user_extended = '0;
  endtask

  task automatic set_vec1();
    clr_fields();
    cmd_opcode = 5'h03;
    cmd_len    = 8'h0F;
    cmd_qos    = 4'h3;
    cmd_prot   = 2'b01;
    cmd_eom    = 1'b1;
  endtask

  initial begin
    n_vec  = 0;
    n_miss = 0;
    nreset = 1'b0;
    clr_fields();
    #2;

`ifdef UMI_CMD_PACK_REG_EN
    set_vec1();
    #1;
    check_vec("reset_clear", packet_cmd, 32'h0000_0000);
    @(posedge clk); #1;
    check_vec("reset_hold", packet_cmd, 32'h0000_0000);
    @(negedge clk);
    nreset = 1'b1;
    @(posedge clk); #1;
    check_vec("first_after_release", packet_cmd, 32'h0053_0F03);
    @(negedge clk);
    clr_fields();
    cmd_opcode = 5'h0F;
    cmd_user_extended = 24'hABCDEF;
    #1;
    check_vec("latency_hold", packet_cmd, 32'h0053_0F03);
    @(posedge clk); #1;
    check_vec("link_registered", packet_cmd, 32'hABCD_EF0F);
    #2;
    nreset = 1'b0;
    #1;
    check_vec("async_clear_mid", packet_cmd, 32'h0000_0000);
    @(posedge clk); #1;
    check_vec("clear_held", packet_cmd, 32'h0000_0000);
`else
    set_vec1();
    #1;
    check_vec("vec1_in_reset", packet_cmd, 32'h0053_0F03);
    nreset = 1'b1;

    set_vec1(); #1;
    check_vec("req_write", packet_cmd, 32'h0053_0F03);

    clr_fields(); cmd_opcode = 5'h09; cmd_atype = 8'h02; cmd_len = 8'h05; #1;
    check_vec("atomic_atype", packet_cmd, 32'h0000_0209);

    clr_fields(); cmd_opcode = 5'h09; cmd_atype = 8'hAA; cmd_len = 8'h55; #1;
    check_vec("atomic_atype2", packet_cmd, 32'h0000_AA09);

    clr_fields(); cmd_opcode = 5'h04; cmd_err = 2'b10; cmd_user = 2'b01; #1;
    check_vec("resp_err", packet_cmd, 32'h0200_0004);

    clr_fields(); cmd_opcode = 5'h02; cmd_err = 2'b01; cmd_user = 2'b10; cmd_len = 8'h03; #1;
    check_vec("resp_read_err_len", packet_cmd, 32'h0100_0302);

    clr_fields(); cmd_opcode = 5'h01; cmd_user = 2'b01; cmd_err = 2'b11; #1;
    check_vec("req_user", packet_cmd, 32'h0100_0001);

    clr_fields(); cmd_opcode = 5'h03; cmd_hostid = 5'h1F; cmd_ex = 1'b1; #1;
    check_vec("hostid_ex", packet_cmd, 32'hFC00_0003);

    clr_fields(); cmd_opcode = 5'h0F; cmd_user_extended = 24'hABCDEF; #1;
    check_vec("req_link", packet_cmd, 32'hABCD_EF0F);

    clr_fields(); cmd_opcode = 5'h0E; cmd_size = 3'b101; cmd_user_extended = 24'h123456;
    cmd_qos = 4'hF; cmd_hostid = 5'h1F; cmd_ex = 1'b1; cmd_len = 8'hFF; cmd_err = 2'b11; #1;
    check_vec("resp_link_ignores", packet_cmd, 32'h1234_56AE);

    clr_fields(); cmd_opcode = 5'h00; cmd_user = 2'b01; cmd_err = 2'b10; cmd_len = 8'hFF; #1;
    check_vec("invalid_user_len", packet_cmd, 32'h0100_FF00);

    clr_fields(); cmd_opcode = 5'h03; cmd_size = 3'h7; cmd_len = 8'hFF; cmd_qos = 4'hF;
    cmd_prot = 2'b11; cmd_eom = 1'b1; cmd_eof = 1'b1; cmd_user = 2'b11; cmd_ex = 1'b1;
    cmd_hostid = 5'h1F; cmd_user_extended = 24'h000000; #1;
    check_vec("all_ones_req", packet_cmd, 32'hFFFF_FFE3);

    clr_fields(); cmd_opcode = 5'h1F; cmd_err = 2'b11; #1;
    check_vec("odd_op_user", packet_cmd, 32'h0000_001F);

    clr_fields(); cmd_opcode = 5'h01; cmd_size = 3'd5; cmd_eof = 1'b1; #1;
    check_vec("size_eof", packet_cmd, 32'h0080_00A1);

    set_vec1();
    nreset = 1'b0;
    @(posedge clk); #1;
    check_vec("reset_no_effect", packet_cmd, 32'h0053_0F03);
    nreset = 1'b1;
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
